// File: rtl/apb_uart_master.sv
// APB requester: turns one valid/ready command into an APB setup/access transfer
// and reports read data, timeout error and wake status on a one-cycle response strobe.
module apb_uart_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_wake,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pwakeup
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             wake;
  logic             timeout_hit;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Control outputs are pure decodes of the state flop, so they change only at the clock edge.
  assign cmd_ready = (state == IDLE);
  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pready is tested before the timeout so a ready on the last allowed cycle still succeeds.
  always_ff @(posedge pclk) begin
    if (rst) begin
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      cnt       <= '0;
      wake      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_wake  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            pwrite <= cmd_write;
            wake   <= 1'b0;
          end
        end
        SETUP: begin
          cnt  <= '0;
          wake <= wake | pwakeup;
        end
        ACCESS: begin
          wake <= wake | pwakeup;
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
            rsp_wake  <= wake | pwakeup;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_wake  <= wake | pwakeup;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_master.sv
// Directed self-checking bench for apb_uart_master with a small APB slave model
// driven from the stimulus tasks.
module tb_apb_uart_master;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_wake;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;
  logic        pwakeup;

  int checkCount = 0;
  int passCount  = 0;

  apb_uart_master #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(64)) dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_wake(rsp_wake),
    .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pwakeup(pwakeup)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issues one command from an IDLE negedge, plays the slave, and measures the transfer.
  // lat is the negedge index (1 = first cycle after accept) at which rsp_valid is seen.
  task automatic applyStimulus(
    input  logic       wr,
    input  logic [31:0] addr,
    input  logic [7:0] wd,
    input  int         waits,
    input  logic [7:0] rd,
    input  logic       wakeInSetup,
    output logic       readyAtStart,
    output int         accCycles,
    output int         lat,
    output logic [7:0] rRdata,
    output logic       rErr,
    output logic       rWake,
    output logic       holdOk,
    output logic       postValid,
    output logic       postReady
  );
    logic done;
    cmd_valid    = 1'b1;
    cmd_write    = wr;
    cmd_addr     = addr;
    cmd_wdata    = wd;
    readyAtStart = cmd_ready;
    accCycles    = 0;
    lat          = -1;
    rRdata       = '0;
    rErr         = 1'b0;
    rWake        = 1'b0;
    holdOk       = 1'b1;
    done         = 1'b0;
    @(posedge pclk);
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge pclk);
      cmd_valid = 1'b0;
      cmd_addr  = 32'hDEAD_BEEF;
      cmd_wdata = 8'h00;
      pwakeup   = (psel && !penable) ? wakeInSetup : 1'b0;
      prdata    = rd;
      pready    = 1'b0;
      if (psel) begin
        if (paddr !== addr || pwrite !== wr || pwdata !== wd) holdOk = 1'b0;
      end
      if (penable) begin
        accCycles++;
        pready = (accCycles == waits + 1);
      end
      if (rsp_valid) begin
        lat    = n;
        rRdata = rsp_rdata;
        rErr   = rsp_err;
        rWake  = rsp_wake;
        done   = 1'b1;
      end
    end
    @(negedge pclk);
    postValid = rsp_valid;
    postReady = cmd_ready;
  endtask

  logic       rdy, hold, pv, pr, err, wk;
  logic [7:0] rdv;
  int         acc, lat;
  int         accIdx [3];
  logic [7:0] gotData [3];
  int         nAcc, nRsp, overlap, rspSeen;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pwakeup = 1'b0;
    repeat (2) @(negedge pclk);
    checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset_psel_penable", {30'd0, psel, penable}, 32'd0);
    checkOutput("reset_rsp_busy", {29'd0, rsp_valid, rsp_err, busy}, 32'd0);
    checkOutput("reset_paddr", paddr, 32'd0);
    rst = 1'b0;
    @(negedge pclk);

    // Write with 12 wait states.
    applyStimulus(1'b1, 32'h10, 8'hA5, 12, 8'h77, 1'b0, rdy, acc, lat, rdv, err, wk, hold, pv, pr);
    checkOutput("wr_ready_at_start", {31'd0, rdy}, 32'd1);
    checkOutput("wr_access_cycles", acc, 32'd13);
    checkOutput("wr_latency", lat, 32'd15);
    checkOutput("wr_rdata", {24'd0, rdv}, 32'd0);
    checkOutput("wr_err", {31'd0, err}, 32'd0);
    checkOutput("wr_hold", {31'd0, hold}, 32'd1);
    checkOutput("wr_rsp_one_cycle", {31'd0, pv}, 32'd0);
    checkOutput("wr_ready_after", {31'd0, pr}, 32'd1);

    // Zero-wait read.
    applyStimulus(1'b0, 32'h14, 8'h00, 0, 8'h3C, 1'b0, rdy, acc, lat, rdv, err, wk, hold, pv, pr);
    checkOutput("rd_latency", lat, 32'd3);
    checkOutput("rd_access_cycles", acc, 32'd1);
    checkOutput("rd_rdata", {24'd0, rdv}, 32'h3C);
    checkOutput("rd_err", {31'd0, err}, 32'd0);
    checkOutput("rd_hold", {31'd0, hold}, 32'd1);

    // Timeout: pready never arrives.
    applyStimulus(1'b0, 32'h18, 8'h00, 1000, 8'hEE, 1'b0, rdy, acc, lat, rdv, err, wk, hold, pv, pr);
    checkOutput("to_access_cycles", acc, 32'd64);
    checkOutput("to_latency", lat, 32'd66);
    checkOutput("to_err", {31'd0, err}, 32'd1);
    checkOutput("to_rdata", {24'd0, rdv}, 32'd0);

    // pready on the 64th access cycle: success beats timeout.
    applyStimulus(1'b0, 32'h1C, 8'h00, 63, 8'hC3, 1'b0, rdy, acc, lat, rdv, err, wk, hold, pv, pr);
    checkOutput("edge_access_cycles", acc, 32'd64);
    checkOutput("edge_err", {31'd0, err}, 32'd0);
    checkOutput("edge_rdata", {24'd0, rdv}, 32'hC3);

    // Back-to-back reads with cmd_valid held high and a zero-wait slave.
    nAcc = 0; nRsp = 0; overlap = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 8'h00;
    pready = 1'b1;
    for (int idx = 0; idx < 30; idx++) begin
      if (idx > 0) @(negedge pclk);
      prdata = paddr[7:0] ^ 8'h5A;
      pready = 1'b1;
      if (busy && cmd_ready) overlap++;
      if (rsp_valid && nRsp < 3) begin
        gotData[nRsp] = rsp_rdata;
        nRsp++;
      end
      if (cmd_valid && cmd_ready) begin
        accIdx[nAcc] = idx;
        nAcc++;
      end else if (cmd_valid) begin
        if (nAcc < 3) cmd_addr = 32'h20 + 32'(nAcc);
        else cmd_valid = 1'b0;
      end
    end
    pready = 1'b0;
    checkOutput("b2b_accepts", nAcc, 32'd3);
    checkOutput("b2b_gap01", accIdx[1] - accIdx[0], 32'd4);
    checkOutput("b2b_gap12", accIdx[2] - accIdx[1], 32'd4);
    checkOutput("b2b_ready_while_busy", overlap, 32'd0);
    checkOutput("b2b_rsp_count", nRsp, 32'd3);
    checkOutput("b2b_rdata0", {24'd0, gotData[0]}, 32'h7A);
    checkOutput("b2b_rdata1", {24'd0, gotData[1]}, 32'h7B);
    checkOutput("b2b_rdata2", {24'd0, gotData[2]}, 32'h78);

    // Reset in the middle of an access phase.
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 8'h11;
    for (int n = 0; n < 10 && !penable; n++) begin
      @(negedge pclk);
      cmd_valid = 1'b0;
    end
    checkOutput("rst_reached_access", {31'd0, penable}, 32'd1);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    checkOutput("rst_psel_penable", {30'd0, psel, penable}, 32'd0);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rspSeen = 0;
    for (int n = 0; n < 5; n++) begin
      if (rsp_valid) rspSeen++;
      @(negedge pclk);
    end
    checkOutput("rst_no_rsp", rspSeen, 32'd0);
    applyStimulus(1'b0, 32'h34, 8'h00, 2, 8'h5E, 1'b0, rdy, acc, lat, rdv, err, wk, hold, pv, pr);
    checkOutput("post_rst_latency", lat, 32'd5);
    checkOutput("post_rst_rdata", {24'd0, rdv}, 32'h5E);

    // Wake status: pulse during setup, then a clean transfer.
    applyStimulus(1'b0, 32'h40, 8'h00, 1, 8'h12, 1'b1, rdy, acc, lat, rdv, err, wk, hold, pv, pr);
    checkOutput("wake_set", {31'd0, wk}, 32'd1);
    checkOutput("wake_rdata", {24'd0, rdv}, 32'h12);
    applyStimulus(1'b0, 32'h44, 8'h00, 0, 8'h34, 1'b0, rdy, acc, lat, rdv, err, wk, hold, pv, pr);
    checkOutput("wake_clear", {31'd0, wk}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
